// File: rtl/image_fetch_ctrl.sv
// Raster-scan ROM read sequencer: issues credit-limited reads into a 3-deep ROM pipeline and
// streams pixels through a small FIFO with sof/eol/eof markers over valid/ready.
module image_fetch_ctrl #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int OW   = CW + 1;
  localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] iss_addr_q;
  logic [2:0]        pv_q;
  logic [ADDR_W-1:0] a0_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;

  logic              push;
  logic              pop;
  logic [OW-1:0]     outstanding;

  assign push    = pv_q[2];
  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid && m_ready;

  // Reads in flight are counted against FIFO space so a stalled sink can never overflow it.
  assign outstanding = OW'(cnt_q) + OW'(pv_q[0]) + OW'(pv_q[1]) + OW'(pv_q[2]) - OW'(pop);
  assign rom_en      = (state_q == RUN) && (outstanding < OW'(FIFO_DEPTH));

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
  assign m_sof    = m_valid && (x_q == '0) && (y_q == '0);
  assign m_eol    = m_valid && (x_q == XW'(IMG_W - 1));
  assign m_eof    = m_eol && (y_q == YW'(IMG_H - 1));

  // Storage needs no reset: pointers and count define what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iss_addr_q <= '0;
      pv_q       <= '0;
      a0_q       <= '0;
      rom_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      pv_q <= {pv_q[1:0], rom_en};
      if (rom_en) begin
        a0_q       <= iss_addr_q;
        iss_addr_q <= iss_addr_q + ADDR_W'(1);
      end
      // The ROM samples the address two cycles after the enable; hold it otherwise.
      if (pv_q[0]) begin
        rom_addr_q <= a0_q;
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);

      if (pop) begin
        if (x_q == XW'(IMG_W - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            iss_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
          end
        end
        RUN: begin
          if (rom_en && (iss_addr_q == ADDR_W'(NPIX - 1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((pv_q == '0) && (cnt_q == CW'(1)) && pop && m_eof) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Directed bench for image_fetch_ctrl with a behavioural 3-cycle ROM and an index-based pixel model.
module tb_image_fetch_ctrl;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int NP   = W * H;
  localparam int LOGN = 2300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        m_ready = 1'b0;
  logic        busy, done, rom_en, m_valid, m_sof, m_eol, m_eof;
  logic [9:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] m_data;

  logic [23:0] mem [NP];
  logic        en_d1 = 1'b0;
  logic        en_d2 = 1'b0;

  int total = 0;
  int bad = 0;
  int k, hs, issued, done_cnt, eol_cnt, exp_idx;

  logic       lg_en [LOGN];
  logic       lg_vld [LOGN];
  logic       lg_busy [LOGN];
  logic       lg_done [LOGN];
  logic       lg_sof [LOGN];
  logic       lg_eol [LOGN];
  logic       lg_eof [LOGN];
  logic [9:0] lg_addr [LOGN];

  typedef struct {
    int         cyc;
    logic       en;
    logic       vld;
    logic       bsy;
    logic       dn;
    logic       sof;
    logic       eol;
    logic       eof;
    logic [9:0] addr;
  } vec_t;
  vec_t tbl [13];

  image_fetch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_eol    (m_eol),
    .m_eof    (m_eof)
  );

  always #5 clk = ~clk;

  // ROM: enable in cycle c, address sampled at end of c+2, data valid in c+3.
  always @(posedge clk) begin
    en_d1 <= rom_en;
    en_d2 <= en_d1;
    if (en_d2) rom_data <= mem[rom_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    k = 0; hs = 0; issued = 0; done_cnt = 0; eol_cnt = 0; exp_idx = 0;
  endtask

  task automatic step(input logic st, input logic rdy, input logic rs);
    @(negedge clk);
    start = st; m_ready = rdy; rst_n = rs;
    #1;
    if (k < LOGN) begin
      lg_en[k] = rom_en;   lg_vld[k] = m_valid; lg_busy[k] = busy; lg_done[k] = done;
      lg_sof[k] = m_sof;   lg_eol[k] = m_eol;   lg_eof[k] = m_eof; lg_addr[k] = rom_addr;
    end
    if (rs) begin
      if (rom_en) issued++;
      if (done) done_cnt++;
      if (m_valid) begin
        chk("pix_data", {8'h0, m_data}, {8'h0, mem[exp_idx]});
        chk("pix_sof", {31'h0, m_sof}, {31'h0, exp_idx == 0});
        chk("pix_eol", {31'h0, m_eol}, {31'h0, (exp_idx % W) == W - 1});
        chk("pix_eof", {31'h0, m_eof}, {31'h0, exp_idx == NP - 1});
        if (rdy) begin
          hs++;
          if (m_eol) eol_cnt++;
          exp_idx = (exp_idx + 1) % NP;
        end
      end
    end
    k++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rom_en"}, {31'h0, rom_en}, 0);
    chk({nm, "_rom_addr"}, {22'h0, rom_addr}, 0);
    chk({nm, "_busy"}, {31'h0, busy}, 0);
    chk({nm, "_done"}, {31'h0, done}, 0);
    chk({nm, "_m_valid"}, {31'h0, m_valid}, 0);
    chk({nm, "_m_data"}, {8'h0, m_data}, 0);
    chk({nm, "_markers"}, {29'h0, m_sof, m_eol, m_eof}, 0);
  endtask

  initial begin
    int nv;
    for (int i = 0; i < NP; i++) begin
      logic [23:0] v;
      v = 24'(i) * 24'h01F3A7;
      mem[i] = v ^ 24'hA5C3E1;
    end

    tbl[0]  = '{0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1]  = '{1,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[2]  = '{3,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[3]  = '{4,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1};
    tbl[4]  = '{5,    1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd2};
    tbl[5]  = '{36,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd33};
    tbl[6]  = '{37,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd34};
    tbl[7]  = '{1024, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1021};
    tbl[8]  = '{1025, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1022};
    tbl[9]  = '{1026, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1023};
    tbl[10] = '{1028, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1023};
    tbl[11] = '{1029, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1023};
    tbl[12] = '{1030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1023};

    // Power-on reset
    clear_stats();
    repeat (3) step(1'b0, 1'b1, 1'b0);
    chk_all_zero("reset");

    // Full-rate frame against the cycle table
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    repeat (1039) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      int c;
      c = tbl[i].cyc;
      chk($sformatf("c%0d_rom_en", c), {31'h0, lg_en[c]}, {31'h0, tbl[i].en});
      chk($sformatf("c%0d_m_valid", c), {31'h0, lg_vld[c]}, {31'h0, tbl[i].vld});
      chk($sformatf("c%0d_busy", c), {31'h0, lg_busy[c]}, {31'h0, tbl[i].bsy});
      chk($sformatf("c%0d_done", c), {31'h0, lg_done[c]}, {31'h0, tbl[i].dn});
      chk($sformatf("c%0d_markers", c), {29'h0, lg_sof[c], lg_eol[c], lg_eof[c]},
          {29'h0, tbl[i].sof, tbl[i].eol, tbl[i].eof});
      chk($sformatf("c%0d_rom_addr", c), {22'h0, lg_addr[c]}, {22'h0, tbl[i].addr});
    end
    chk("full_issued", issued, NP);
    chk("full_pixels", hs, NP);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_eol_cnt", eol_cnt, W);

    // 20-cycle sink stall mid-frame
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    for (int j = 1; j < 1100; j++) begin
      step(1'b0, !(j >= 300 && j < 320), 1'b1);
      if (j == 319) begin
        chk("stall_rom_en", {31'h0, rom_en}, 0);
        chk("stall_fifo_full", issued - hs, 8);
      end
    end
    nv = 0;
    for (int c = 5; c <= 1048; c++) nv += int'(lg_vld[c]);
    chk("stall_no_gap", nv, 1044);
    chk("stall_done_cyc", {31'h0, lg_done[1049]}, 1);
    chk("stall_pixels", hs, NP);
    chk("stall_done_cnt", done_cnt, 1);

    // start pulses while busy are ignored
    clear_stats();
    for (int j = 0; j < 1040; j++) step(j == 0 || j == 100 || j == 600, 1'b1, 1'b1);
    chk("ign_pixels", hs, NP);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_idle_after", {31'h0, lg_busy[1039]}, 0);

    // Random 50% sink readiness
    clear_stats();
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    repeat (3500) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    chk("rand_pixels", hs, NP);
    chk("rand_done_cnt", done_cnt, 1);

    // Reset at pixel 500, then a clean frame
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 2000 && hs < 500; j++) step(1'b0, 1'b1, 1'b1);
    chk("rst_reach_500", hs, 500);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk_all_zero("midrst");
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    repeat (1039) step(1'b0, 1'b1, 1'b1);
    chk("postrst_first_vld", {31'h0, lg_vld[5]}, 1);
    chk("postrst_pixels", hs, NP);
    chk("postrst_done_cnt", done_cnt, 1);

    // start held high: back-to-back frames one IDLE cycle apart
    clear_stats();
    repeat (2060) step(1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b1);
    chk("b2b_done1", {31'h0, lg_done[1029]}, 1);
    chk("b2b_idle_gap", {31'h0, lg_busy[1030]}, 0);
    chk("b2b_restart", {31'h0, lg_busy[1031]}, 1);
    chk("b2b_done2", {31'h0, lg_done[2059]}, 1);
    chk("b2b_pixels", hs, 2 * NP);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_no_third", {31'h0, lg_busy[2061]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
